// File: rtl/sdhci_dat_pkg.sv
// Shared definitions for the SDHCI DAT-line receive and transmit paths.
//   CRC16_POLY / CRC_LEN : CRC16-CCITT generator (x^16+x^12+x^5+1) and its length
//   dat_rx_state_e       : DAT-line block state sequence
//   crc16_step()         : one serial CRC16 update for a single data bit
package sdhci_dat_pkg;

    localparam int unsigned CRC_LEN    = 16;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    typedef enum logic [2:0] {
        DAT_IDLE       = 3'd0,
        DAT_WAIT_START = 3'd1,
        DAT_DATA       = 3'd2,
        DAT_CRC        = 3'd3,
        DAT_END        = 3'd4,
        DAT_DONE       = 3'd5
    } dat_rx_state_e;

    // Serial CRC16: feedback is the outgoing MSB xor the incoming bit.
    function automatic logic [CRC_LEN-1:0] crc16_step(input logic [CRC_LEN-1:0] crc,
                                                      input logic              bit_in);
        logic fb;
        fb = crc[CRC_LEN-1] ^ bit_in;
        return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/dat_crc16.sv
// Single-lane serial CRC16 generator (init 0), one bit per enabled cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear to 0 (wins over en_i)
//   en_i, bit_i   : shift bit_i into the CRC when en_i is high
//   crc_o         : current CRC register
module dat_crc16
    import sdhci_dat_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic               bit_i,
    output logic [CRC_LEN-1:0] crc_o
);

    logic [CRC_LEN-1:0] crc_q;
    logic [CRC_LEN-1:0] crc_d;

    // Next CRC value
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/dat_rx_deserializer.sv
// DAT-line receive deserializer: waits for a start bit, shifts one block in
// 1-bit or 4-bit mode, packs bytes little-endian into 32-bit words, then checks
// the per-lane CRC16 and the end bit.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   sd_clk_en_i, dat_i   : SD-clock sample strobe and DAT[3:0]
//   start_i              : arm for one block (IDLE only), captures block_size_i
//                          and bus_width_is_4_i
//   data_valid_o, data_o : one-cycle word strobe and registered word
//   done_o               : one-cycle pulse after the end bit
//   crc_err_o            : CRC mismatch on any active lane, held to next start
//   end_bit_err_o        : end bit 0 on any active lane, held to next start
module dat_rx_deserializer
    import sdhci_dat_pkg::*;
#(
    parameter int unsigned MaxBlockBitSize = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       sd_clk_en_i,
    input  logic [3:0]                 dat_i,
    input  logic                       start_i,
    input  logic [MaxBlockBitSize-1:0] block_size_i,
    input  logic                       bus_width_is_4_i,
    output logic                       data_valid_o,
    output logic [31:0]                data_o,
    output logic                       done_o,
    output logic                       crc_err_o,
    output logic                       end_bit_err_o
);

    localparam int unsigned CntW   = MaxBlockBitSize + 3;
    localparam int unsigned NLanes = 4;

    dat_rx_state_e state_q, state_d;
    logic [CntW-1:0] rem_q, rem_d;          // data samples left minus one
    logic [7:0]      byte_q, byte_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [31:0]     word_q, word_d;        // partially filled word
    logic            w4_q, w4_d;
    logic [3:0]      crc_cnt_q, crc_cnt_d;
    logic            crc_acc_q, crc_acc_d;  // mismatch seen so far in CRC phase
    logic            data_valid_q, data_valid_d;
    logic [31:0]     data_q, data_d;
    logic            done_q, done_d;
    logic            crc_err_q, crc_err_d;
    logic            end_err_q, end_err_d;

    logic               crc_clr_c;
    logic               crc_en_c;
    logic [NLanes-1:0]  active_c;
    logic [NLanes-1:0]  crc_bit_c;
    logic [3:0]         crc_idx_c;
    logic [7:0]         new_byte_c;
    logic               byte_done_c;
    logic [31:0]        word_nxt_c;
    logic [CntW-1:0]    blk_ext_c;
    logic [CntW-1:0]    total_c;
    logic [CRC_LEN-1:0] crc_v [NLanes];

    // Per-lane CRC generators; lanes 1..3 only advance in 4-bit mode
    for (genvar l = 0; l < NLanes; l++) begin : g_crc
        dat_crc16 u_crc (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (crc_clr_c),
            .en_i   (crc_en_c & active_c[l]),
            .bit_i  (dat_i[l]),
            .crc_o  (crc_v[l])
        );
    end

    // Datapath helpers shared by the FSM
    always_comb begin
        active_c    = w4_q ? 4'hF : 4'h1;
        new_byte_c  = w4_q ? {byte_q[3:0], dat_i} : {byte_q[6:0], dat_i[0]};
        // rem counts down to 0; a byte closes on every 2nd (4-bit) or 8th (1-bit) sample
        byte_done_c = w4_q ? (rem_q[0] == 1'b0) : (rem_q[2:0] == 3'd0);
        word_nxt_c  = word_q;
        word_nxt_c[{byte_idx_q, 3'b000} +: 8] = new_byte_c;
        crc_idx_c   = 4'(CRC_LEN - 1) - crc_cnt_q;
        for (int l = 0; l < NLanes; l++) begin
            crc_bit_c[l] = crc_v[l][crc_idx_c];
        end
        blk_ext_c = CntW'(block_size_i);
        total_c   = bus_width_is_4_i ? (blk_ext_c << 1) : (blk_ext_c << 3);
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        byte_d       = byte_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        w4_d         = w4_q;
        crc_cnt_d    = crc_cnt_q;
        crc_acc_d    = crc_acc_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        done_d       = 1'b0;
        crc_err_d    = crc_err_q;
        end_err_d    = end_err_q;
        crc_clr_c    = 1'b0;
        crc_en_c     = 1'b0;

        unique case (state_q)
            DAT_IDLE: begin
                if (start_i) begin
                    w4_d       = bus_width_is_4_i;
                    rem_d      = total_c - CntW'(1);
                    byte_d     = '0;
                    byte_idx_d = '0;
                    word_d     = '0;
                    crc_cnt_d  = '0;
                    crc_acc_d  = 1'b0;
                    crc_err_d  = 1'b0;
                    end_err_d  = 1'b0;
                    crc_clr_c  = 1'b1;
                    if (block_size_i == '0) begin
                        state_d = DAT_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DAT_WAIT_START;
                    end
                end
            end
            DAT_WAIT_START: begin
                if (sd_clk_en_i && !dat_i[0]) begin
                    state_d = DAT_DATA;
                end
            end
            DAT_DATA: begin
                if (sd_clk_en_i) begin
                    crc_en_c = 1'b1;
                    byte_d   = new_byte_c;
                    rem_d    = rem_q - CntW'(1);
                    if (byte_done_c) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        // Emit a full word, or the zero-padded tail on the last sample
                        if (byte_idx_q == 2'd3 || rem_q == '0) begin
                            data_d       = word_nxt_c;
                            data_valid_d = 1'b1;
                            word_d       = '0;
                        end else begin
                            word_d = word_nxt_c;
                        end
                    end
                    if (rem_q == '0) begin
                        state_d   = DAT_CRC;
                        crc_cnt_d = '0;
                    end
                end
            end
            DAT_CRC: begin
                if (sd_clk_en_i) begin
                    crc_acc_d = crc_acc_q | (|((dat_i ^ crc_bit_c) & active_c));
                    crc_cnt_d = crc_cnt_q + 4'd1;
                    if (crc_cnt_q == 4'(CRC_LEN - 1)) begin
                        state_d = DAT_END;
                    end
                end
            end
            DAT_END: begin
                if (sd_clk_en_i) begin
                    end_err_d = |(~dat_i & active_c);
                    crc_err_d = crc_acc_q;
                    done_d    = 1'b1;
                    state_d   = DAT_DONE;
                end
            end
            DAT_DONE: begin
                state_d = DAT_IDLE;
            end
            default: begin
                state_d = DAT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= DAT_IDLE;
            rem_q        <= '0;
            byte_q       <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            w4_q         <= 1'b0;
            crc_cnt_q    <= '0;
            crc_acc_q    <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            done_q       <= 1'b0;
            crc_err_q    <= 1'b0;
            end_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            byte_q       <= byte_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            w4_q         <= w4_d;
            crc_cnt_q    <= crc_cnt_d;
            crc_acc_q    <= crc_acc_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            done_q       <= done_d;
            crc_err_q    <= crc_err_d;
            end_err_q    <= end_err_d;
        end
    end

    assign data_valid_o  = data_valid_q;
    assign data_o        = data_q;
    assign done_o        = done_q;
    assign crc_err_o     = crc_err_q;
    assign end_bit_err_o = end_err_q;

endmodule

// File: tb/tb_dat_rx_deserializer.sv
// Randomized self-checking bench for dat_rx_deserializer against a
// byte/lane-level reference model (CRC by polynomial long division).
module tb_dat_rx_deserializer;

    localparam int unsigned MBS = 10;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic           sd_clk_en_i;
    logic [3:0]     dat_i;
    logic           start_i;
    logic [MBS-1:0] block_size_i;
    logic           bus_width_is_4_i;
    logic           data_valid_o;
    logic [31:0]    data_o;
    logic           done_o;
    logic           crc_err_o;
    logic           end_bit_err_o;

    dat_rx_deserializer #(.MaxBlockBitSize(MBS)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .sd_clk_en_i      (sd_clk_en_i),
        .dat_i            (dat_i),
        .start_i          (start_i),
        .block_size_i     (block_size_i),
        .bus_width_is_4_i (bus_width_is_4_i),
        .data_valid_o     (data_valid_o),
        .data_o           (data_o),
        .done_o           (done_o),
        .crc_err_o        (crc_err_o),
        .end_bit_err_o    (end_bit_err_o)
    );

    always #5 clk = ~clk;

    int unsigned checks_total  = 0;
    int unsigned checks_passed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Output monitor
    int unsigned cyc = 0;
    logic [31:0] got_q[$];
    int          done_cnt = 0;
    int unsigned done_cyc = 0;
    logic        got_crc_err = 1'b0;
    logic        got_end_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid_o) got_q.push_back(data_o);
        if (done_o) begin
            done_cnt++;
            done_cyc    = cyc;
            got_crc_err = crc_err_o;
            got_end_err = end_bit_err_o;
        end
    end

    logic [7:0] byte_arr [0:1023];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One SD sample, preceded by 0..gap_max cycles with the strobe low and junk on dat_i
    task automatic drive_sample(input logic [3:0] v, input int gap_max, output int unsigned pres_cyc);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int i = 0; i < g; i++) begin
            sd_clk_en_i = 1'b0;
            dat_i       = 4'($urandom);
            tick();
        end
        sd_clk_en_i = 1'b1;
        dat_i       = v;
        pres_cyc    = cyc;
        tick();
        sd_clk_en_i = 1'b0;
        dat_i       = 4'($urandom);
    endtask

    // Reference CRC: remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] ref_crc(input logic [3:0] s[$], input int lane);
        logic [16:0] r;
        logic [3:0]  e;
        logic        b;
        r = '0;
        for (int i = 0; i < s.size() + 16; i++) begin
            b = 1'b0;
            if (i < s.size()) begin
                e = s[i];
                b = e[lane];
            end
            r = {r[15:0], b};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    task automatic run_block(input string tag, input bit w4, input int n, input int gap_max,
                             input int pre_idle, input logic [3:0] crc_xor,
                             input bit crc0_ovr_en, input logic [15:0] crc0_ovr,
                             input logic [3:0] end_zero, input bit start_glitch,
                             input bit check_lat);
        logic [3:0]  samp_q[$];
        logic [15:0] model_crc [4];
        logic [15:0] sent_crc [4];
        logic [3:0]  v;
        logic [3:0]  act;
        logic [7:0]  b;
        logic [31:0] w;
        logic        exp_crc_err;
        logic        exp_end_err;
        int          nw;
        int unsigned pc;
        int unsigned start_cyc;

        act = w4 ? 4'hF : 4'h1;
        for (int i = 0; i < n; i++) begin
            b = byte_arr[i];
            if (w4) begin
                samp_q.push_back(b[7:4]);
                samp_q.push_back(b[3:0]);
            end else begin
                for (int k = 7; k >= 0; k--) samp_q.push_back({3'($urandom), b[k]});
            end
        end
        exp_crc_err = 1'b0;
        for (int l = 0; l < 4; l++) begin
            model_crc[l] = ref_crc(samp_q, l);
            sent_crc[l]  = model_crc[l] ^ (crc_xor[l] ? 16'h0001 : 16'h0000);
            if (l == 0 && crc0_ovr_en) sent_crc[l] = crc0_ovr;
            if (act[l] && sent_crc[l] != model_crc[l]) exp_crc_err = 1'b1;
        end
        exp_end_err = |(end_zero & act);

        got_q.delete();
        done_cnt = 0;
        start_i          = 1'b1;
        block_size_i     = MBS'(n);
        bus_width_is_4_i = w4;
        tick();
        start_i          = 1'b0;
        block_size_i     = MBS'($urandom);
        bus_width_is_4_i = 1'($urandom);

        for (int i = 0; i < pre_idle; i++) drive_sample(4'hF, gap_max, pc);
        if (check_lat) check_eq({tag, " quiet"}, 32'(got_q.size()) + 32'(done_cnt), 32'd0);

        drive_sample(w4 ? 4'h0 : {3'($urandom), 1'b0}, gap_max, start_cyc);
        for (int i = 0; i < samp_q.size(); i++) begin
            if (start_glitch && i == 2) begin
                start_i          = 1'b1;
                block_size_i     = MBS'($urandom);
                bus_width_is_4_i = ~w4;
            end
            drive_sample(samp_q[i], gap_max, pc);
            start_i = 1'b0;
        end
        for (int k = 15; k >= 0; k--) begin
            v = 4'($urandom);
            for (int l = 0; l < 4; l++) if (act[l]) v[l] = sent_crc[l][k];
            drive_sample(v, gap_max, pc);
        end
        drive_sample(~end_zero, gap_max, pc);

        for (int i = 0; i < 8 && done_cnt == 0; i++) tick();
        tick();
        tick();

        nw = (n + 3) / 4;
        check_eq({tag, " done"}, 32'(done_cnt), 32'd1);
        check_eq({tag, " nwords"}, 32'(got_q.size()), 32'(nw));
        for (int k = 0; k < nw && k < got_q.size(); k++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                if (4 * k + j < n) w = w | (32'(byte_arr[4 * k + j]) << (8 * j));
            check_eq($sformatf("%s w%0d", tag, k), got_q[k], w);
        end
        check_eq({tag, " crc_err"}, 32'(got_crc_err), 32'(exp_crc_err));
        check_eq({tag, " end_err"}, 32'(got_end_err), 32'(exp_end_err));
        check_eq({tag, " crc_hold"}, 32'(crc_err_o), 32'(exp_crc_err));
        if (check_lat) check_eq({tag, " latency"}, done_cyc - start_cyc, 32'(2 * n + 18));
    endtask

    initial begin
        int unsigned pc;
        rst_ni = 1'b0;
        sd_clk_en_i = 1'b0;
        dat_i = 4'hF;
        start_i = 1'b0;
        block_size_i = '0;
        bus_width_is_4_i = 1'b0;
        repeat (3) tick();
        check_eq("rst valid", 32'(data_valid_o), 32'd0);
        check_eq("rst data", data_o, 32'd0);
        check_eq("rst done", 32'(done_o), 32'd0);
        check_eq("rst crc", 32'(crc_err_o), 32'd0);
        check_eq("rst end", 32'(end_bit_err_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        byte_arr[0] = 8'hDE; byte_arr[1] = 8'hAD; byte_arr[2] = 8'hBE; byte_arr[3] = 8'hEF;
        run_block("deadbeef", 1'b0, 4, 1, 2, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);

        for (int i = 0; i < 512; i++) byte_arr[i] = 8'hFF;
        run_block("ff512", 1'b0, 512, 0, 0, 4'h0, 1'b1, 16'h7FA1, 4'h0, 1'b0, 1'b0);
        run_block("ff512bad", 1'b0, 512, 0, 0, 4'h0, 1'b1, 16'h7FA0, 4'h0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) byte_arr[i] = 8'(i + 1);
        run_block("w4blk6", 1'b1, 6, 1, 1, 4'h0, 1'b0, 16'h0, 4'h2, 1'b0, 1'b0);

        // Zero-length block: done on the next cycle, errors cleared
        start_i = 1'b1;
        block_size_i = '0;
        bus_width_is_4_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_eq("blk0 done", 32'(done_o), 32'd1);
        check_eq("blk0 valid", 32'(data_valid_o), 32'd0);
        check_eq("blk0 crc", 32'(crc_err_o), 32'd0);
        check_eq("blk0 end", 32'(end_bit_err_o), 32'd0);
        tick();
        check_eq("blk0 pulse", 32'(done_o), 32'd0);
        tick();

        for (int i = 0; i < 24; i++) byte_arr[i] = 8'($urandom);
        run_block("div1", 1'b1, 24, 0, 100, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        run_block("glitch", 1'b0, 9, 1, 0, 4'h0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0);

        // Reset in the middle of DATA after one word has gone out
        start_i = 1'b1;
        block_size_i = MBS'(16);
        bus_width_is_4_i = 1'b1;
        tick();
        start_i = 1'b0;
        drive_sample(4'h0, 0, pc);
        for (int i = 0; i < 10; i++) drive_sample(4'($urandom), 0, pc);
        rst_ni = 1'b0;
        #3;
        check_eq("midrst outs", {27'd0, data_valid_o, done_o, crc_err_o, end_bit_err_o}, 32'd0);
        check_eq("midrst data", data_o, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        got_q.delete();
        done_cnt = 0;
        drive_sample(4'hF, 0, pc);
        drive_sample(4'h0, 0, pc);
        for (int i = 0; i < 60; i++) drive_sample(4'($urandom), 0, pc);
        repeat (4) tick();
        check_eq("unarmed quiet", 32'(got_q.size()) + 32'(done_cnt), 32'd0);
        for (int i = 0; i < 7; i++) byte_arr[i] = 8'($urandom);
        run_block("postrst", 1'b1, 7, 1, 1, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            bit         w4;
            int         n;
            logic [3:0] cx;
            logic [3:0] ez;
            w4 = 1'($urandom);
            n  = int'($urandom_range(40, 1));
            for (int i = 0; i < n; i++) byte_arr[i] = 8'($urandom);
            cx = ($urandom_range(2, 0) == 0) ? 4'($urandom) : 4'h0;
            ez = ($urandom_range(2, 0) == 0) ? 4'($urandom) : 4'h0;
            run_block($sformatf("rnd%0d", t), w4, n, 2, int'($urandom_range(3, 0)),
                      cx, 1'b0, 16'h0, ez, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
